// File: rtl/pe_feed_pkg.sv
// Shared constants and slot helpers for the PE-array input stream feeder.
// Frame layout: W_SLOTS weight slots followed by ROW_LENGTH activation slots.
package pe_feed_pkg;

  localparam int DATA_W     = 27;
  localparam int ROW_LENGTH = 7;
  localparam int O_CH       = 9;
  localparam int FIFO_DEPTH = 16;

  localparam int W_SLOTS   = O_CH * ROW_LENGTH;
  localparam int ACT_BASE  = W_SLOTS;
  localparam int FRAME_LEN = W_SLOTS + ROW_LENGTH;
  localparam int SLOT_W    = $clog2(FRAME_LEN);
  localparam int ADDR_W    = 6;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic {
    SLOT_WEIGHT = 1'b0,
    SLOT_ACT    = 1'b1
  } slot_kind_e;

  function automatic slot_kind_e slot_kind(input slot_t s);
    return (s >= SLOT_W'(ACT_BASE)) ? SLOT_ACT : SLOT_WEIGHT;
  endfunction

  function automatic slot_t next_slot(input slot_t s);
    return (s == SLOT_W'(FRAME_LEN - 1)) ? '0 : s + 1'b1;
  endfunction

endpackage

// File: rtl/pe_act_fifo.sv
// Synchronous activation FIFO with occupancy count; power-of-two depth.
// Pointers and count reset asynchronously, storage is left unreset.
module pe_act_fifo #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pe_stream_feeder.sv
// Transmit side of the PE-array stream: weight slots then activation slots, one word per cycle.
// Optional macro WEIGHT_DBUF_EN adds a shadow weight bank swapped in at frame boundaries.
module pe_stream_feeder
  import pe_feed_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              w_we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              w_commit,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_data,
  output logic [DATA_W-1:0] data_out,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic              frame_start,
  output logic              frame_valid,
  output logic              underflow,
  output logic              commit_done
);

  logic [DATA_W-1:0] live [W_SLOTS];
  logic              frame_ok;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              in_act;
  logic              wrap;
  logic              w_hit;
  logic              pop;

  assign wrap   = (slot_cnt == SLOT_W'(FRAME_LEN - 1));
  assign in_act = (slot_kind(slot_cnt) == SLOT_ACT);
  assign w_hit  = w_we && (w_addr < ADDR_W'(W_SLOTS));
  assign pop    = frame_ok && in_act && !fifo_empty;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) slot_cnt <= '0;
    else        slot_cnt <= next_slot(slot_cnt);
  end

  // Decide one slot ahead whether the coming activation slots can all be served.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      frame_ok <= 1'b0;
    end else if (slot_cnt == SLOT_W'(ACT_BASE - 1)) begin
      frame_ok <= (fifo_count >= CNT_W'(ROW_LENGTH));
    end
  end

`ifdef WEIGHT_DBUF_EN
  logic [DATA_W-1:0] shadow [W_SLOTS];
  logic              pending;
  logic              swap;

  // A commit seen in the last slot still lands on the wrap edge.
  assign swap = wrap && (pending || w_commit);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < W_SLOTS; i++) begin
        shadow[i] <= '0;
        live[i]   <= '0;
      end
      pending     <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      if (w_hit) shadow[w_addr] <= w_data;
      if (swap) begin
        for (int i = 0; i < W_SLOTS; i++) live[i] <= shadow[i];
      end
      pending     <= swap ? 1'b0 : (pending || w_commit);
      commit_done <= swap;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = w_commit;
  assign commit_done   = 1'b0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < W_SLOTS; i++) live[i] <= '0;
    end else if (w_hit) begin
      live[w_addr] <= w_data;
    end
  end
`endif

  pe_act_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (act_valid),
    .pop   (pop),
    .wdata (act_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    data_out = '0;
    if (!in_act)       data_out = live[slot_cnt[ADDR_W-1:0]];
    else if (frame_ok) data_out = fifo_head;
  end

  assign act_ready   = !fifo_full;
  assign frame_start = (slot_cnt == '0);
  assign frame_valid = frame_ok && in_act;
  assign underflow   = !frame_ok && (slot_cnt == SLOT_W'(ACT_BASE));

endmodule

// File: tb/tb_pe_stream_feeder.sv
// Scoreboard bench for pe_stream_feeder: stimulus queues expected slot outputs by cycle, a monitor compares.
module tb_pe_stream_feeder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        w_we;
  logic [5:0]  w_addr;
  logic [26:0] w_data;
  logic        w_commit;
  logic        act_valid;
  logic        act_ready;
  logic [26:0] act_data;
  logic [26:0] data_out;
  logic [6:0]  slot_cnt;
  logic        frame_start;
  logic        frame_valid;
  logic        underflow;
  logic        commit_done;

`ifdef WEIGHT_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  pe_stream_feeder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .w_we        (w_we),
    .w_addr      (w_addr),
    .w_data      (w_data),
    .w_commit    (w_commit),
    .act_valid   (act_valid),
    .act_ready   (act_ready),
    .act_data    (act_data),
    .data_out    (data_out),
    .slot_cnt    (slot_cnt),
    .frame_start (frame_start),
    .frame_valid (frame_valid),
    .underflow   (underflow),
    .commit_done (commit_done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          at;
    string       tag;
    int          slot;
    logic [26:0] data;
    bit          fv;
    bit          uf;
    bit          cd;
    bit          rdy;
    bit          c_main;
    bit          c_rdy;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          gcyc    = 0;
  logic [26:0] wm [63];

  always @(posedge clk_in) gcyc <= gcyc + 1;

  function automatic void sb_add(input exp_t e);
    int i;
    i = sb.size();
    while (i > 0 && sb[i-1].at > e.at) i--;
    sb.insert(i, e);
  endfunction

  function automatic void exp_main(input int at, input string tag, input int slot,
                                   input logic [26:0] d, input bit fv, input bit uf, input bit cd);
    exp_t e;
    e.at = at; e.tag = tag; e.slot = slot; e.data = d;
    e.fv = fv; e.uf = uf; e.cd = cd; e.rdy = 1'b0;
    e.c_main = 1'b1; e.c_rdy = 1'b0;
    sb_add(e);
  endfunction

  function automatic void exp_rdy(input int at, input string tag, input bit r);
    exp_t e;
    e.at = at; e.tag = tag; e.slot = 0; e.data = '0;
    e.fv = 1'b0; e.uf = 1'b0; e.cd = 1'b0; e.rdy = r;
    e.c_main = 1'b0; e.c_rdy = 1'b1;
    sb_add(e);
  endfunction

  // Slots 1..last of a frame whose slot 0 is observed at cycle g0.
  function automatic void exp_frame(input int g0, input int last, input string tag,
                                    input bit wsel, input bit ok, input logic [26:0] abase);
    logic [26:0] d;
    for (int s = 1; s <= last; s++) begin
      if (s < 63) d = wsel ? wm[s] : 27'd0;
      else        d = ok ? abase + 27'(s - 63) : 27'd0;
      exp_main(g0 + s, tag, s, d, ok && (s >= 63), !ok && (s == 63), 1'b0);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #2;
      while (sb.size() > 0 && sb[0].at < gcyc) begin
        e = sb.pop_front();
        n_tests++; n_fail++;
        $display("FAIL %s slot %0d: check for cycle %0d never sampled, now cycle %0d",
                 e.tag, e.slot, e.at, gcyc);
      end
      while (sb.size() > 0 && sb[0].at == gcyc) begin
        e = sb.pop_front();
        if (e.c_main) begin
          n_tests++;
          if (slot_cnt !== 7'(e.slot) || data_out !== e.data || frame_start !== (e.slot == 0) ||
              frame_valid !== e.fv || underflow !== e.uf || commit_done !== e.cd) begin
            n_fail++;
            $display("FAIL %s slot %0d: got slot=%0d data=%h fs=%b fv=%b uf=%b cd=%b, want slot=%0d data=%h fs=%b fv=%b uf=%b cd=%b",
                     e.tag, e.slot, slot_cnt, data_out, frame_start, frame_valid, underflow, commit_done,
                     e.slot, e.data, (e.slot == 0), e.fv, e.uf, e.cd);
          end
        end
        if (e.c_rdy) begin
          n_tests++;
          if (act_ready !== e.rdy) begin
            n_fail++;
            $display("FAIL %s: act_ready got %b, want %b", e.tag, act_ready, e.rdy);
          end
        end
      end
    end
  end

  task automatic idle();
    w_we = 1'b0; w_addr = '0; w_data = '0; w_commit = 1'b0;
    act_valid = 1'b0; act_data = '0;
  endtask

  task automatic wr(input int a, input logic [26:0] d);
    w_we = 1'b1; w_addr = 6'(a); w_data = d;
  endtask

  task automatic push_act(input logic [26:0] d);
    act_valid = 1'b1; act_data = d;
  endtask

  initial begin
    int g0;
    rst_in = 1'b1;
    idle();
    for (int i = 0; i < 63; i++) wm[i] = '0;
    repeat (2) @(negedge clk_in);
    exp_main(gcyc + 1, "reset", 0, 27'd0, 1'b0, 1'b0, 1'b0);
    exp_rdy(gcyc + 1, "reset_rdy", 1'b1);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Frame 0: nothing loaded, every slot zero, starved frame.
    g0 = gcyc;
    exp_frame(g0, 69, "f0_idle", 1'b0, 1'b0, 27'd0);
    exp_main(g0 + 70, "f0_next", 0, 27'd0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin idle(); @(negedge clk_in); end

    // Frame 1: load w[i]=i+1 slot by slot, queue 7 activations, commit in the last slot.
    g0 = gcyc;
    exp_frame(g0, 69, "f1_load", 1'b0, 1'b1, 27'h100);
    exp_rdy(g0 + 7, "f1_rdy", 1'b1);
    for (int i = 0; i < 63; i++) wm[i] = 27'(i + 1);
    exp_main(g0 + 70, "f1_next", 0, wm[0], 1'b0, 1'b0, DBUF);
    for (int s = 0; s < 70; s++) begin
      idle();
      if (s < 63) wr(s, 27'(s + 1));
      if (s < 7) push_act(27'h100 + 27'(s));
      if (s == 69) w_commit = 1'b1;
      @(negedge clk_in);
    end

    // Frame 2: only 6 activations before the decision slot, 7th arrives late.
    g0 = gcyc;
    exp_frame(g0, 69, "f2_starve", 1'b1, 1'b0, 27'd0);
    exp_main(g0 + 70, "f2_next", 0, wm[0], 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin
      idle();
      if (s < 6) push_act(27'h200 + 27'(s));
      if (s == 65) push_act(27'h206);
      @(negedge clk_in);
    end

    // Frame 3: the 7 queued words go out.
    g0 = gcyc;
    exp_frame(g0, 69, "f3_late", 1'b1, 1'b1, 27'h200);
    exp_main(g0 + 70, "f3_next", 0, wm[0], 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin idle(); @(negedge clk_in); end

    // Frame 4: fill to 16, refused pushes while full, push+pop at slot 64.
    g0 = gcyc;
    exp_frame(g0, 69, "f4_full", 1'b1, 1'b1, 27'h300);
    exp_rdy(g0 + 15, "f4_rdy15", 1'b1);
    exp_rdy(g0 + 16, "f4_rdy16", 1'b0);
    exp_rdy(g0 + 62, "f4_rdy62", 1'b0);
    exp_rdy(g0 + 63, "f4_rdy63", 1'b0);
    exp_rdy(g0 + 64, "f4_rdy64", 1'b1);
    exp_rdy(g0 + 65, "f4_rdy65", 1'b1);
    exp_main(g0 + 70, "f4_next", 0, wm[0], 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin
      idle();
      if (s < 16)       push_act(27'h300 + 27'(s));
      else if (s < 64)  push_act(27'h3FF);
      else if (s == 64) push_act(27'h310);
      @(negedge clk_in);
    end

    // Frame 5: 10 queued, next 7 drain.
    g0 = gcyc;
    exp_frame(g0, 69, "f5_drain", 1'b1, 1'b1, 27'h307);
    exp_main(g0 + 70, "f5_next", 0, wm[0], 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin idle(); @(negedge clk_in); end

    // Frame 6: 3 left is not enough; top up to 7 after the decision.
    g0 = gcyc;
    exp_frame(g0, 69, "f6_short", 1'b1, 1'b0, 27'd0);
    exp_main(g0 + 70, "f6_next", 0, wm[0], 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin
      idle();
      if (s >= 64 && s <= 67) push_act(27'h311 + 27'(s - 64));
      @(negedge clk_in);
    end

    // Frame 7: mid-frame weight writes and a commit at slot 30.
    g0 = gcyc;
    wm[50] = DBUF ? 27'd51 : 27'h555;
    exp_frame(g0, 69, "f7_wmid", 1'b1, 1'b1, 27'h30E);
    wm[5]  = 27'hABC;
    wm[50] = 27'h555;
    exp_main(g0 + 70, "f7_next", 0, wm[0], 1'b0, 1'b0, DBUF);
    for (int s = 0; s < 70; s++) begin
      idle();
      if (s == 20) wr(50, 27'h555);
      if (s == 21) wr(5, 27'hABC);
      if (s == 30) w_commit = 1'b1;
      @(negedge clk_in);
    end

    // Frame 8: new weights visible, 3 activations queued, reset at slot 40.
    g0 = gcyc;
    exp_frame(g0, 40, "f8_pre", 1'b1, 1'b0, 27'd0);
    for (int s = 0; s < 40; s++) begin
      idle();
      if (s < 3) push_act(27'h3A0 + 27'(s));
      @(negedge clk_in);
    end
    rst_in = 1'b1;
    idle();
    exp_main(gcyc + 1, "rst_mid", 0, 27'd0, 1'b0, 1'b0, 1'b0);
    exp_rdy(gcyc + 1, "rst_mid_rdy", 1'b1);
    @(negedge clk_in);
    rst_in = 1'b0;

    // Frame 9: banks cleared and FIFO emptied, so 4 pushes still starve.
    g0 = gcyc;
    for (int i = 0; i < 63; i++) wm[i] = '0;
    exp_frame(g0, 69, "f9_post", 1'b0, 1'b0, 27'd0);
    exp_main(g0 + 70, "f9_next", 0, 27'd0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 70; s++) begin
      idle();
      if (s < 4) push_act(27'h400 + 27'(s));
      @(negedge clk_in);
    end

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk_in);
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d checks still pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
